// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder: turns each qualified twisted-ring sample into a phase index,
// checks that codes arrive in ring order, tracks lock and counts completed revolutions.
module johnson_phase_decoder #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CYC_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             jc_in,
  input  logic                     jc_valid,
  input  logic                     clear_err,
  output logic [$clog2(2*N)-1:0]   phase_idx,
  output logic [2*N-1:0]           phase_onehot,
  output logic                     phase_valid,
  output logic                     illegal,
  output logic                     seq_err,
  output logic                     locked,
  output logic [CYC_W-1:0]         cyc_cnt,
  output logic                     wrap_pulse
);

  localparam int unsigned STATES = 2 * N;
  localparam int unsigned PW     = $clog2(STATES);
  localparam int unsigned SW     = 4;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     steps_q, steps_d, steps_inc;
  logic [PW-1:0]     phase_d, succ;
  logic [STATES-1:0] onehot_d;
  logic              valid_d, illegal_d, seq_set, seq_err_d, locked_d, wrap_d;
  logic [CYC_W-1:0]  cyc_d;
  logic              dec_legal, is_succ, is_hold;
  logic [PW-1:0]     dec_phase;

  // Canonical code of phase k: top k ones for k<=N, otherwise low 2N-k ones.
  function automatic logic [N-1:0] johnson_code(input int unsigned k);
    logic [N-1:0] ones;
    ones = '1;
    if (k <= N) return ~(ones >> k);
    return ones >> (k - N);
  endfunction

  always_comb begin : decode
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int unsigned k = 0; k < STATES; k++) begin
      if (jc_in == johnson_code(k)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(k);
      end
    end
  end

  assign succ      = (phase_idx == PW'(STATES - 1)) ? '0 : phase_idx + PW'(1);
  assign is_succ   = (dec_phase == succ);
  assign is_hold   = (dec_phase == phase_idx);
  assign steps_inc = steps_q + SW'(1);

  // Next-state and registered-output values; only qualified samples move anything.
  always_comb begin : next_state
    state_d   = state_q;
    steps_d   = steps_q;
    phase_d   = phase_idx;
    valid_d   = phase_valid;
    cyc_d     = cyc_cnt;
    illegal_d = 1'b0;
    wrap_d    = 1'b0;
    seq_set   = 1'b0;
    if (jc_valid) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        valid_d   = 1'b0;
        state_d   = UNLOCKED;
      end else begin
        valid_d = 1'b1;
        phase_d = dec_phase;
        case (state_q)
          UNLOCKED: begin
            steps_d = '0;
            state_d = ACQUIRE;
          end
          ACQUIRE: begin
            if (is_succ) begin
              steps_d = steps_inc;
              if (steps_inc == SW'(LOCK_CNT)) state_d = LOCKED;
            end else if (!is_hold) begin
              steps_d = '0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              if (phase_idx == PW'(STATES - 1)) begin
                cyc_d  = cyc_cnt + CYC_W'(1);
                wrap_d = 1'b1;
              end
            end else if (!is_hold) begin
              seq_set = 1'b1;
              state_d = UNLOCKED;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
    // A new sequence error wins over a simultaneous clear.
    seq_err_d = seq_set | (seq_err & ~clear_err);
    locked_d  = (state_d == LOCKED);
    onehot_d  = valid_d ? (STATES'(1) << phase_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q      <= UNLOCKED;
      steps_q      <= '0;
      phase_idx    <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      illegal      <= 1'b0;
      seq_err      <= 1'b0;
      locked       <= 1'b0;
      cyc_cnt      <= '0;
      wrap_pulse   <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      phase_idx    <= phase_d;
      phase_onehot <= onehot_d;
      phase_valid  <= valid_d;
      illegal      <= illegal_d;
      seq_err      <= seq_err_d;
      locked       <= locked_d;
      cyc_cnt      <= cyc_d;
      wrap_pulse   <= wrap_d;
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: a table-driven behavioural model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] jc_in = 4'b0000;
  logic       jc_valid = 1'b0;
  logic       clear_err = 1'b0;
  logic [2:0] phase_idx;
  logic [7:0] phase_onehot;
  logic       phase_valid, illegal, seq_err, locked, wrap_pulse;
  logic [7:0] cyc_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_phase_decoder #(.N(4), .LOCK_CNT(3), .CYC_W(8)) dut (
    .clk(clk), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid), .clear_err(clear_err),
    .phase_idx(phase_idx), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
    .illegal(illegal), .seq_err(seq_err), .locked(locked), .cyc_cnt(cyc_cnt),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  // Model: last legal phase, run of correct steps since an anchor (-1 = none), lock flag.
  int m_phase = 0, m_streak = -1, m_cyc = 0;
  bit m_valid = 0, m_locked = 0, m_ill = 0, m_wrap = 0, m_seq = 0;
  int t_idx, t_nxt, t_phase, t_streak, t_cyc;
  bit t_valid, t_locked, t_ill, t_wrap, t_seq;

  always @(posedge clk or posedge reset) begin : model
    if (reset) begin
      m_phase <= 0; m_streak <= -1; m_cyc <= 0;
      m_valid <= 0; m_locked <= 0; m_ill <= 0; m_wrap <= 0; m_seq <= 0;
    end else begin
      t_phase = m_phase; t_streak = m_streak; t_cyc = m_cyc;
      t_valid = m_valid; t_locked = m_locked; t_ill = 0; t_wrap = 0; t_seq = 0;
      if (jc_valid) begin
        t_idx = lookup(jc_in);
        t_nxt = (m_phase + 1) % 8;
        if (t_idx < 0) begin
          t_ill = 1; t_valid = 0; t_locked = 0; t_streak = -1;
        end else begin
          if (m_locked) begin
            if (t_idx == t_nxt) begin
              if (t_idx == 0) begin t_cyc = (m_cyc + 1) % 256; t_wrap = 1; end
            end else if (t_idx != m_phase) begin
              t_seq = 1; t_locked = 0; t_streak = -1;
            end
          end else if (m_streak < 0) begin
            t_streak = 0;
          end else if (t_idx == t_nxt) begin
            t_streak = m_streak + 1;
            if (t_streak == 3) t_locked = 1;
          end else if (t_idx != m_phase) begin
            t_streak = 0;
          end
          t_phase = t_idx; t_valid = 1;
        end
      end
      m_phase <= t_phase; m_streak <= t_streak; m_cyc <= t_cyc;
      m_valid <= t_valid; m_locked <= t_locked; m_ill <= t_ill; m_wrap <= t_wrap;
      m_seq <= t_seq ? 1'b1 : (clear_err ? 1'b0 : m_seq);
    end
  end

  always @(negedge clk) begin : compare
    chk("m_phase_idx", int'(phase_idx), m_phase);
    chk("m_onehot", int'(phase_onehot), m_valid ? (1 << m_phase) : 0);
    chk("m_valid", int'(phase_valid), int'(m_valid));
    chk("m_illegal", int'(illegal), int'(m_ill));
    chk("m_seq_err", int'(seq_err), int'(m_seq));
    chk("m_locked", int'(locked), int'(m_locked));
    chk("m_cyc_cnt", int'(cyc_cnt), m_cyc);
    chk("m_wrap", int'(wrap_pulse), int'(m_wrap));
  end

  task automatic step(input logic [3:0] c, input logic v, input logic ce);
    jc_in = c; jc_valid = v; clear_err = ce;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int p;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase_idx", int'(phase_idx), 0);
    chk("rst_onehot", int'(phase_onehot), 0);
    chk("rst_valid", int'(phase_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_cyc", int'(cyc_cnt), 0);
    reset = 1'b0;

    // Free-running counter from reset: lock after the fourth sample, wrap on 7->0.
    for (int i = 0; i < 4; i++) begin
      step(codes[i], 1'b1, 1'b0);
      chk("run_phase", int'(phase_idx), i);
      if (i == 2) chk("pre_lock", int'(locked), 0);
      if (i == 2) chk("onehot_p2", int'(phase_onehot), 8'b0000_0100);
    end
    chk("lock_after_4", int'(locked), 1);
    for (int i = 4; i <= 8; i++) step(codes[i % 8], 1'b1, 1'b0);
    chk("first_wrap", int'(wrap_pulse), 1);
    chk("first_cyc", int'(cyc_cnt), 1);
    step(codes[1], 1'b1, 1'b0);
    chk("wrap_one_cycle", int'(wrap_pulse), 0);

    // Illegal code while locked, then relock over four legal samples.
    step(4'b1010, 1'b1, 1'b0);
    chk("ill_pulse", int'(illegal), 1);
    chk("ill_unlock", int'(locked), 0);
    chk("ill_no_seq", int'(seq_err), 0);
    chk("ill_valid", int'(phase_valid), 0);
    chk("ill_onehot", int'(phase_onehot), 0);
    chk("ill_hold_idx", int'(phase_idx), 1);
    step(codes[2], 1'b1, 1'b0);
    chk("ill_cleared", int'(illegal), 0);
    step(codes[3], 1'b1, 1'b0);
    step(codes[4], 1'b1, 1'b0);
    chk("relock_not_yet", int'(locked), 0);
    step(codes[5], 1'b1, 1'b0);
    chk("relock", int'(locked), 1);

    // Skip 0011 -> 0000 while locked: sticky seq_err until clear_err.
    step(codes[6], 1'b1, 1'b0);
    step(codes[0], 1'b1, 1'b0);
    chk("skip_seq", int'(seq_err), 1);
    chk("skip_unlock", int'(locked), 0);
    step(codes[1], 1'b1, 1'b0);
    chk("seq_sticky", int'(seq_err), 1);
    step(codes[2], 1'b1, 1'b1);
    chk("seq_cleared", int'(seq_err), 0);
    step(codes[3], 1'b1, 1'b0);
    step(codes[4], 1'b1, 1'b0);
    chk("relock2", int'(locked), 1);

    // Holds and jc_valid gaps carrying a garbage code.
    repeat (5) step(codes[4], 1'b1, 1'b0);
    chk("hold_locked", int'(locked), 1);
    chk("hold_cyc", int'(cyc_cnt), 1);
    for (int k = 5; k <= 12; k++) begin
      step(codes[k % 8], 1'b1, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
    end
    chk("gap_cyc", int'(cyc_cnt), 2);
    chk("gap_locked", int'(locked), 1);
    chk("gap_phase", int'(phase_idx), 4);
    chk("gap_no_ill", int'(illegal), 0);

    // Run revolutions until the counter wraps 255 -> 0.
    p = 4;
    n = 0;
    while (cyc_cnt != 8'd255 && n < 4000) begin
      p = (p + 1) % 8;
      step(codes[p], 1'b1, 1'b0);
      n++;
    end
    chk("reach_255", int'(cyc_cnt), 255);
    while (p != 7) begin
      p = p + 1;
      step(codes[p], 1'b1, 1'b0);
    end
    step(codes[0], 1'b1, 1'b0);
    chk("cyc_wrap_zero", int'(cyc_cnt), 0);
    chk("cyc_wrap_pulse", int'(wrap_pulse), 1);
    step(codes[1], 1'b1, 1'b0);
    step(codes[3], 1'b1, 1'b1);
    chk("set_beats_clear", int'(seq_err), 1);
    chk("skip2_unlock", int'(locked), 0);

    // Fresh run to cyc_cnt=5, then an asynchronous reset mid-cycle.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int s = 0; s <= 42; s++) step(codes[s % 8], 1'b1, 1'b0);
    chk("pre_rst_cyc", int'(cyc_cnt), 5);
    chk("pre_rst_locked", int'(locked), 1);
    chk("pre_rst_phase", int'(phase_idx), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_phase", int'(phase_idx), 0);
    chk("arst_onehot", int'(phase_onehot), 0);
    chk("arst_valid", int'(phase_valid), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_cyc", int'(cyc_cnt), 0);
    chk("arst_seq", int'(seq_err), 0);
    chk("arst_ill", int'(illegal), 0);
    chk("arst_wrap", int'(wrap_pulse), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(codes[0], 1'b1, 1'b0);
    chk("post_rst_valid", int'(phase_valid), 1);
    step(codes[1], 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
